// File: rtl/tristate_bus_arbiter_pkg.sv
// Shared definitions for the tristate bus arbiter: state encoding,
// default parameter values and the owner-index width helper.
package tristate_bus_arbiter_pkg;

    localparam int DEF_N           = 4;
    localparam int DEF_MAX_HOLD    = 8;
    localparam int DEF_TURN_CYCLES = 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN  = 2'd1,
        TURN = 2'd2
    } state_t;

    // Width of an agent index; never narrower than one bit.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tristate_bus_arbiter_if.sv
// Bus-side signal bundle between the arbiter and its N register agents.
// The arbiter uses the master view, the agents the slave view.
interface tristate_bus_arbiter_if #(
    parameter int N = 4
);
    import tristate_bus_arbiter_pkg::*;

    localparam int ID_W = id_width(N);

    logic [N-1:0]    req;
    logic [N-1:0]    gnt;
    logic [N-1:0]    oe;
    logic [ID_W-1:0] gnt_id;
    logic            bus_busy;
    logic            hold_expired;

    modport master (
        input  req,
        output gnt,
        output oe,
        output gnt_id,
        output bus_busy,
        output hold_expired
    );

    modport slave (
        output req,
        input  gnt,
        input  oe,
        input  gnt_id,
        input  bus_busy,
        input  hold_expired
    );

endinterface

// File: rtl/tristate_bus_arbiter_rr_pick.sv
// Combinational round-robin pick: first set request bit strictly after
// `last`, wrapping modulo N. Kept standalone so other port arbiters can reuse it.
module tristate_bus_arbiter_rr_pick
    import tristate_bus_arbiter_pkg::*;
#(
    parameter int N    = 4,
    parameter int ID_W = id_width(N)
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] last,
    output logic [ID_W-1:0] winner,
    output logic            any_req
);

    logic [ID_W-1:0] idx;

    // Scan from the farthest candidate to the nearest so the nearest set bit wins.
    always_comb begin
        winner  = '0;
        any_req = 1'b0;
        idx     = '0;
        for (int k = N; k >= 1; k--) begin
            idx = ID_W'((int'(last) + k) % N);
            if (req[idx]) begin
                winner  = idx;
                any_req = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tristate_bus_arbiter.sv
// Round-robin owner sequencer for a shared single-driver tristate bus.
// Grants are registered and one-hot, every handover passes through a
// released turnaround window, and a hold limit preempts a hogging owner
// only when someone else is waiting.
module tristate_bus_arbiter
    import tristate_bus_arbiter_pkg::*;
#(
    parameter int N           = DEF_N,
    parameter int MAX_HOLD    = DEF_MAX_HOLD,
    parameter int TURN_CYCLES = DEF_TURN_CYCLES
) (
    input  logic                  clk,
    input  logic                  rst,
    tristate_bus_arbiter_if.master bus
);

    localparam int ID_W = id_width(N);
    localparam int HW   = $clog2(MAX_HOLD + 1);
    localparam int TW   = $clog2(TURN_CYCLES + 1);

    state_t          state_reg;
    logic [ID_W-1:0] last_reg;
    logic [HW-1:0]   hold_reg;
    logic [TW-1:0]   turn_reg;
    logic [N-1:0]    gnt_reg;
    logic [ID_W-1:0] gnt_id_reg;
    logic            hold_expired_reg;

    logic [ID_W-1:0] winner;
    logic            any_req;
    logic            owner_req;
    logic            others_req;

    tristate_bus_arbiter_rr_pick #(
        .N    (N),
        .ID_W (ID_W)
    ) u_pick (
        .req     (bus.req),
        .last    (last_reg),
        .winner  (winner),
        .any_req (any_req)
    );

    assign owner_req  = bus.req[gnt_id_reg];
    assign others_req = |(bus.req & ~gnt_reg);

    // Owner FSM: all bus-facing outputs are registered here so req never
    // reaches oe combinationally.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg        <= IDLE;
            last_reg         <= ID_W'(N - 1);
            hold_reg         <= '0;
            turn_reg         <= '0;
            gnt_reg          <= '0;
            gnt_id_reg       <= '0;
            hold_expired_reg <= 1'b0;
        end else begin
            hold_expired_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (any_req) begin
                        state_reg  <= OWN;
                        gnt_reg    <= {{(N-1){1'b0}}, 1'b1} << winner;
                        gnt_id_reg <= winner;
                        last_reg   <= winner;
                        hold_reg   <= '0;
                    end
                end
                OWN: begin
                    if (!owner_req) begin
                        // Voluntary release wins even when the limit is hit now.
                        state_reg  <= TURN;
                        gnt_reg    <= '0;
                        gnt_id_reg <= '0;
                        turn_reg   <= '0;
                    end else if (hold_reg == HW'(MAX_HOLD - 1)) begin
                        if (others_req) begin
                            state_reg        <= TURN;
                            gnt_reg          <= '0;
                            gnt_id_reg       <= '0;
                            turn_reg         <= '0;
                            hold_expired_reg <= 1'b1;
                        end else begin
                            // Nobody waiting: restart the window, no gap.
                            hold_reg <= '0;
                        end
                    end else begin
                        hold_reg <= hold_reg + HW'(1);
                    end
                end
                TURN: begin
                    if (turn_reg == TW'(TURN_CYCLES - 1)) begin
                        if (any_req) begin
                            state_reg  <= OWN;
                            gnt_reg    <= {{(N-1){1'b0}}, 1'b1} << winner;
                            gnt_id_reg <= winner;
                            last_reg   <= winner;
                            hold_reg   <= '0;
                        end else begin
                            state_reg <= IDLE;
                        end
                    end else begin
                        turn_reg <= turn_reg + TW'(1);
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    gnt_reg   <= '0;
                end
            endcase
        end
    end

    assign bus.gnt          = gnt_reg;
    assign bus.oe           = gnt_reg;
    assign bus.gnt_id       = gnt_id_reg;
    assign bus.bus_busy     = (state_reg != IDLE);
    assign bus.hold_expired = hold_expired_reg;

endmodule

// File: tb/tb_tristate_bus_arbiter.sv
// Self-checking bench: a behavioural owner/turnaround model is compared
// with the arbiter every cycle, directed scenarios pin literal values,
// and a random phase exercises arbitrary request patterns.
module tb_tristate_bus_arbiter;

    localparam int N           = 4;
    localparam int MAX_HOLD    = 8;
    localparam int TURN_CYCLES = 1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    tristate_bus_arbiter_if #(.N(N)) bus ();

    tristate_bus_arbiter #(
        .N           (N),
        .MAX_HOLD    (MAX_HOLD),
        .TURN_CYCLES (TURN_CYCLES)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // owner = -1 when nobody owns; turn_left = released cycles still to go;
    // held = edges since the current ownership window started.
    int m_owner = -1;
    int m_held  = 0;
    int m_turn  = 0;
    int m_last  = N - 1;
    bit m_pulse = 1'b0;

    task automatic model_pick(input logic [N-1:0] r);
        bit found;
        found   = 1'b0;
        m_owner = -1;
        for (int k = 1; k <= N; k++) begin
            int idx;
            idx = (m_last + k) % N;
            if (!found && r[idx]) begin
                found   = 1'b1;
                m_owner = idx;
                m_last  = idx;
                m_held  = 0;
            end
        end
    endtask

    // Model advances on the same edges as the design.
    always @(posedge clk or negedge rst) begin
        logic [N-1:0] r;
        if (!rst) begin
            m_owner = -1; m_held = 0; m_turn = 0; m_last = N - 1; m_pulse = 1'b0;
        end else begin
            r       = bus.req;
            m_pulse = 1'b0;
            if (m_turn > 0) begin
                m_turn--;
                if (m_turn == 0) model_pick(r);
            end else if (m_owner < 0) begin
                model_pick(r);
            end else if (!r[m_owner]) begin
                m_owner = -1;
                m_turn  = TURN_CYCLES;
            end else begin
                m_held++;
                if (m_held == MAX_HOLD) begin
                    if ((r & ~(4'b0001 << m_owner)) != 0) begin
                        m_owner = -1;
                        m_turn  = TURN_CYCLES;
                        m_pulse = 1'b1;
                    end else begin
                        m_held = 0;
                    end
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    logic [N-1:0] prev_oe = '0;
    logic [N-1:0] exp_gnt;
    int pulse_cnt = 0;
    int grants_q[$];

    // Compare every output with the model on the falling edge.
    always @(negedge clk) begin
        exp_gnt = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
        check("gnt", 32'(bus.gnt), 32'(exp_gnt));
        check("oe", 32'(bus.oe), 32'(exp_gnt));
        check("gnt_id", 32'(bus.gnt_id), (m_owner >= 0) ? 32'(m_owner) : 32'd0);
        check("bus_busy", 32'(bus.bus_busy), 32'((m_owner >= 0) || (m_turn > 0)));
        check("hold_expired", 32'(bus.hold_expired), 32'(m_pulse));
        check("oe_onehot0", 32'($onehot0(bus.oe)), 32'd1);
        check("oe_direct_switch", 32'((prev_oe != 0) && (bus.oe != 0) && (bus.oe != prev_oe)), 32'd0);
        if (bus.hold_expired) pulse_cnt++;
        if (bus.gnt != 0 && prev_oe == 0) grants_q.push_back(int'(bus.gnt_id));
        prev_oe = bus.oe;
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 64 && (bus.bus_busy || bus.gnt != 0); i++) step();
        check("wait_idle", 32'(bus.bus_busy), 32'd0);
    endtask

    task automatic do_reset();
        #1 rst = 1'b0;
        step();
        rst = 1'b1;
    endtask

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_owners[5];
        exp_owners = '{0, 1, 2, 3, 0};

        // Reset held with all requests up.
        bus.req = 4'b1111;
        rst     = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("rst_gnt", 32'(bus.gnt), 32'd0);
        check("rst_oe", 32'(bus.oe), 32'd0);
        check("rst_gnt_id", 32'(bus.gnt_id), 32'd0);
        check("rst_busy", 32'(bus.bus_busy), 32'd0);
        rst = 1'b1;
        step();
        check("first_gnt", 32'(bus.gnt), 32'h1);
        bus.req = 4'b0000;
        wait_idle();

        // Single agent grant and release.
        bus.req = 4'b0100;
        step();
        check("single_gnt", 32'(bus.gnt), 32'h4);
        check("single_oe", 32'(bus.oe), 32'h4);
        check("single_id", 32'(bus.gnt_id), 32'd2);
        bus.req = 4'b0000;
        step();
        check("release_oe", 32'(bus.oe), 32'd0);
        check("release_busy", 32'(bus.bus_busy), 32'd1);
        step();
        check("release_idle", 32'(bus.bus_busy), 32'd0);

        // Full contention round-robin with preemption.
        do_reset();
        bus.req = 4'b1111;
        grants_q.delete();
        pulse_cnt = 0;
        repeat (44) step();
        check("rr_pulses", 32'(pulse_cnt), 32'd4);
        check("rr_grants", 32'(grants_q.size()), 32'd5);
        for (int i = 0; i < 5 && i < grants_q.size(); i++)
            check("rr_owner", 32'(grants_q[i]), 32'(exp_owners[i]));
        bus.req = 4'b0000;
        wait_idle();

        // No contention: owner keeps the bus across hold windows.
        bus.req = 4'b0001;
        step();
        for (int i = 0; i < 20; i++) begin
            check("solo_gnt", 32'(bus.gnt), 32'h1);
            check("solo_pulse", 32'(bus.hold_expired), 32'd0);
            step();
        end
        bus.req = 4'b0000;
        wait_idle();

        // Asynchronous reset while agent 3 owns the bus.
        bus.req = 4'b1000;
        step();
        check("own3_gnt", 32'(bus.gnt), 32'h8);
        #1 rst = 1'b0;
        #1;
        check("async_oe", 32'(bus.oe), 32'd0);
        check("async_busy", 32'(bus.bus_busy), 32'd0);
        step();
        bus.req = 4'b1001;
        rst     = 1'b1;
        step();
        check("post_rst_gnt", 32'(bus.gnt), 32'h1);
        bus.req = 4'b1000;
        step();
        check("post_rst_turn", 32'(bus.gnt), 32'd0);
        check("post_rst_busy", 32'(bus.bus_busy), 32'd1);
        step();
        check("post_rst_gnt3", 32'(bus.gnt), 32'h8);
        check("post_rst_id3", 32'(bus.gnt_id), 32'd3);
        bus.req = 4'b0000;
        wait_idle();

        // Release/request race and a late request during turnaround.
        do_reset();
        bus.req = 4'b0010;
        step();
        check("race_own1", 32'(bus.gnt), 32'h2);
        step();
        bus.req = 4'b0100;
        step();
        check("race_turn", 32'(bus.gnt), 32'd0);
        bus.req = 4'b0101;
        step();
        check("race_gnt2", 32'(bus.gnt), 32'h4);
        check("race_id2", 32'(bus.gnt_id), 32'd2);
        bus.req = 4'b0000;
        wait_idle();

        // Random request traffic with persistent requesters.
        for (int i = 0; i < 600; i++) begin
            logic [N-1:0] r;
            r = bus.req;
            for (int b = 0; b < N; b++)
                if ($urandom_range(0, 7) == 0) r[b] = ~r[b];
            bus.req = r;
            step();
        end
        bus.req = 4'b0000;
        wait_idle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/tristate_bus_arbiter.md
Name: tristate_bus_arbiter

Overview:
- Round-robin arbiter and sequencer for a shared single-driver tristate data bus connecting N register agents.
- Each agent's bus driver is gated by one bit of `oe`, as in `data = oe[i] ? val : 1'bz`.
- Guarantees at most one driver at any time.
- Inserts mandatory all-released turnaround cycles between owners.
- Enforces a hold limit so that no agent can starve the others.

Parameters:
- N, 4: number of requesting agents (≥2).
- MAX_HOLD, 8: maximum consecutive owned cycles while another request is pending (≥1).
- TURN_CYCLES, 1: bus-released cycles between any release and the next grant (≥1).

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- req  in  N  per-agent bus request; held high for as long as the agent needs the bus.
- gnt  out  N  one-hot grant (all zeros when nobody owns the bus); registered.
- oe  out  N  per-agent tristate drive enable; always equal to gnt; registered.
- gnt_id  out  max(1,$clog2(N))  index of the current owner; 0 when idle.
- bus_busy  out  1  high in OWN and TURN states.
- hold_expired  out  1  one-cycle pulse when an owner is preempted by MAX_HOLD.

Behaviour:
- Reset (rst=0, async, independent of clk):
  - gnt=0, oe=0, gnt_id=0, bus_busy=0, hold_expired=0.
  - state=IDLE, hold counter=0.
  - Round-robin pointer last=N-1, so req[0] has first priority.
- Outputs remain registered; no combinational path from req to oe/gnt.
- Arbitration pick:
  - Choose the first set req bit searching last+1, last+2, … wrapping modulo N.
  - On each grant, last ← winner.
- IDLE:
  - If any req bit is sampled high at an edge, go to OWN at that same edge.
  - gnt/oe = one-hot(winner); gnt_id=winner; hold counter=0.
  - Grant latency is 1 edge from req sampled high.
- OWN:
  - Hold counter increments each cycle and saturates at MAX_HOLD-1.
  - Release when req[owner]==0 is sampled. Go to TURN, gnt=oe=0, hold_expired=0.
  - Preempt when counter==MAX_HOLD-1, req[owner] is still 1, and any other req bit is 1.
    - Go to TURN; gnt=oe=0; hold_expired pulses for one cycle.
  - If the counter is at MAX_HOLD-1 and no other request is pending:
    - Stay in OWN and clear the counter to 0.
    - The owner keeps the bus with no gap.
  - If the owner drops req on the same edge the limit is reached, treat it as a normal release: hold_expired=0.
- TURN:
  - All oe=0 for exactly TURN_CYCLES cycles; a turnaround counter is used.
  - On the last TURN cycle, apply the arbitration pick to req as sampled at that edge.
    - If any bit is set, go to OWN with the winner.
    - Otherwise go to IDLE.
  - A preempted owner is still eligible, but loses to any other requester by pointer order.
- Requests arriving or dropping during TURN have no effect until the final TURN edge.
- Invariants:
  - oe is always zero or one-hot (\$onehot0).
  - oe never changes directly from one non-zero value to another.
  - gnt_id matches gnt.
- Reset during OWN or TURN clears oe immediately. After rst returns high, the first grant comes no earlier than the next edge.

Decomposition:
- Shared include tristate_bus_defs.vh:
  - State encoding localparams: IDLE=2'd0, OWN=2'd1, TURN=2'd2.
  - Default N, MAX_HOLD and TURN_CYCLES.
- One sub-module, rr_pick (combinational).
  - Inputs: req[N-1:0], last index.
  - Outputs: winner index, any_req.
  - Reused by future register-file port arbiters.

Test Plan:
- Reset: hold rst=0 with req=4'b1111 for 3 edges → gnt=0, oe=0, gnt_id=0, bus_busy=0. Release rst → gnt=4'b0001 after the next edge.
- Single agent: req=4'b0100 → gnt=oe=4'b0100 and gnt_id=2 after 1 edge. Drop req → oe=0 next edge, bus_busy=1 for exactly 1 cycle, then IDLE.
- Round-robin with preemption: req=4'b1111 held → owners 0,1,2,3,0 in order, each 8 cycles, hold_expired pulse at each handover, one oe=0 cycle between owners, \$onehot0(oe) never violated.
- No contention: req=4'b0001 held 20 cycles → gnt=4'b0001 continuously, no TURN, hold_expired never asserted.
- Async reset mid-OWN: owner 3 active, drive rst low between edges → oe=0 before the next clk edge. After release, req=4'b1001 → agent 0 granted first, agent 3 after 0 releases plus 1 TURN cycle.
- Release/request race: owner 1 drops req while req[2] rises in the same cycle → TURN for 1 cycle, then gnt=4'b0100. Rising req[0] mid-TURN with last=1 still loses to 2.
